kseq_ctrl: RTL and testbench
============================

KSEQ_CTRL -- requirements
Module: kseq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand lane width in bits.
REQ-002 SHALL have parameter SIZE, default 8, PE array dimension (SIZE x SIZE).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle job launch, sampled only in IDLE.
REQ-006 SHALL have port k_len, input, 16, beats per tile, latched on start.
REQ-007 SHALL have port n_tiles, input, 16, tiles per job, latched on start.
REQ-008 SHALL have ports a_valid (input, 1) and a_ready (output, 1), the beat handshake.
REQ-009 SHALL have ports a_data and b_data, input, SIZE*DATA_WIDTH each: left-edge and top-edge lanes; lane k occupies [k*DATA_WIDTH-1 -: DATA_WIDTH]; lane SIZE is top row / left column.
REQ-010 SHALL have ports in_left and in_up, output, SIZE*DATA_WIDTH each, skewed operands driving the array edges.
REQ-011 SHALL have port finish, output, SIZE*SIZE; bit (i-1)*SIZE+j-1 drives PE(i,j).
REQ-012 SHALL have ports busy (output, 1), tile_done (output, 1, one-cycle pulse) and tile_idx (output, 16, index of the tile whose results are now on out_matrix).

Function
REQ-013 SHALL implement FSM IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE.
REQ-014 IDLE: start=1 and n_tiles!=0 -> STREAM; start=1 and n_tiles=0 -> stays IDLE, no finish wave; k_len=0 treated as 1.
REQ-015 STREAM: a_ready=1; beat accepted when a_valid&&a_ready; after n_tiles*k_len accepted beats -> FLUSH.
REQ-016 In STREAM, a cycle with no accepted beat SHALL inject an all-zero bubble beat with no tile-start flag (adds zero to partial sums).
REQ-017 A tile-start flag SHALL accompany each accepted beat whose in-tile beat counter is 0.
REQ-018 FLUSH: lasts one cycle; injects one zero beat carrying a tile-start flag (closes last tile); -> DRAIN.
REQ-019 DRAIN: zero beats; -> IDLE once the flag shift register is empty (2*SIZE-1 cycles).
REQ-020 Skew: in_left lane i and in_up lane j SHALL be registered outputs delayed by (SIZE-i) and (SIZE-j) extra cycles respectively; a beat accepted at cycle c reaches lane SIZE at c+1.
REQ-021 finish bit of PE(i,j) SHALL be high exactly at cycle c+1+(SIZE-i)+(SIZE-j) for each tile-start beat at c, implemented as taps of one 2*SIZE-1 deep flag shift register.
REQ-022 tile_done SHALL pulse one cycle after the finish wave reaches PE(1,1), for every wave except the job's first; exactly n_tiles pulses per job.
REQ-023 tile_idx SHALL increment after each tile_done, starting at 0 per job.
REQ-024 busy SHALL be 1 in every state except IDLE; start while busy is ignored.
REQ-025 Beat and tile counters SHALL be 16 bits; product n_tiles*k_len SHALL be counted without overflow (nested counters).

Reset
REQ-026 rst SHALL force IDLE, a_ready=0, busy=0, tile_done=0, tile_idx=0, finish=0, in_left=0, in_up=0, and clear all skew and flag registers, including mid-job.

Configuration
REQ-027 With macro KSEQ_STALL_CNT_EN defined, an output stall_cycles (32 bits, reset 0, cleared on start) SHALL count STREAM cycles with a_valid=0; without it the port and counter SHALL not exist.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the skew-depth function.
REQ-029 One sub-module kseq_skew_line (per-lane parameterised-depth delay register) SHALL implement REQ-020.

Verification
REQ-030 SIZE=2, k_len=2, n_tiles=1, a_valid always 1: exactly 1 tile_done, 6 cycles after first accept; finish[3] high at c+1, finish[0] high at c+3.
REQ-031 Stall: a_valid low 3 cycles mid-tile -> zero beats injected, results unchanged vs. no-stall run, tile_done delayed 3 cycles.
REQ-032 n_tiles=3, k_len=4 -> exactly 3 tile_done pulses, tile_idx 0,1,2, busy falls after DRAIN.
REQ-033 n_tiles=0 start -> busy stays 0, finish stays 0.
REQ-034 rst asserted in STREAM -> next cycle all outputs 0, IDLE; new start runs correctly.
REQ-035 KSEQ_STALL_CNT_EN defined, 5 stall cycles -> stall_cycles=5.

Source files
------------

// File: rtl/kseq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// kseq_ctrl_pkg
// Shared definitions for the systolic-array job sequencer:
//   state_t     - sequencer FSM states
//   skew_depth  - number of register stages for a given edge lane
// ---------------------------------------------------------------------------
package kseq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Lane SIZE gets the single output register; every lane below it gets
    // one extra stage per step away from the top/left edge.
    function automatic int skew_depth(input int size, input int lane);
        return size - lane + 1;
    endfunction

endpackage

// File: rtl/kseq_ctrl_skew_line.sv
// ---------------------------------------------------------------------------
// kseq_skew_line
// Fixed-depth delay line for one operand lane.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, clears every stage
//   data    - lane value entering the line
//   delayed - lane value DEPTH cycles later (registered)
// ---------------------------------------------------------------------------
module kseq_skew_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= data;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/kseq_ctrl.sv
// ---------------------------------------------------------------------------
// kseq_ctrl
// Job sequencer for a SIZE x SIZE systolic array: accepts operand beats,
// skews them onto the array edges and issues the diagonal finish wave that
// closes each tile.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - one-cycle job launch (honoured only in IDLE)
//   k_len, n_tiles    - beats per tile (0 means 1) and tiles per job
//   a_valid / a_ready - beat handshake
//   a_data, b_data    - left-edge / top-edge lanes, lane k at [k*DW-1 -: DW]
//   in_left, in_up    - skewed lanes driving the array edges
//   finish            - per-PE tile-close strobe, bit (i-1)*SIZE+j-1 = PE(i,j)
//   busy              - high outside IDLE
//   tile_done         - one-cycle pulse when a tile's results are complete
//   tile_idx          - index of the tile reported by tile_done
//   stall_cycles      - only with KSEQ_STALL_CNT_EN: STREAM cycles without
//                       a_valid, cleared on start
// Build option: define KSEQ_STALL_CNT_EN to add the stall counter.
// ---------------------------------------------------------------------------
module kseq_ctrl
    import kseq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                k_len,
    input  logic [15:0]                n_tiles,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [SIZE*DATA_WIDTH-1:0] a_data,
    input  logic [SIZE*DATA_WIDTH-1:0] b_data,
    output logic [SIZE*DATA_WIDTH-1:0] in_left,
    output logic [SIZE*DATA_WIDTH-1:0] in_up,
    output logic [SIZE*SIZE-1:0]       finish,
    output logic                       busy,
    output logic                       tile_done,
    output logic [15:0]                tile_idx
`ifdef KSEQ_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int FLAG_DEPTH = 2*SIZE - 1;

    state_t                     state, state_next;
    logic [15:0]                k_lat, n_lat, beat_cnt, tile_cnt;
    logic                       accept, flag_in, last_beat, launch;
    logic [FLAG_DEPTH-1:0]      flag_sr, flag_shifted;
    logic                       first_wave;
    logic [SIZE*DATA_WIDTH-1:0] beat_a, beat_b;

    assign launch       = (state == IDLE) && start;
    assign last_beat    = (beat_cnt == k_lat - 16'd1) && (tile_cnt == n_lat - 16'd1);
    assign flag_shifted = flag_sr << 1;

    // Anything not accepted this cycle goes into the array as a zero beat.
    assign beat_a = accept ? a_data : '0;
    assign beat_b = accept ? b_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        accept     = 1'b0;
        flag_in    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && (n_tiles != 16'd0)) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                a_ready = 1'b1;
                accept  = a_valid;
                flag_in = a_valid && (beat_cnt == 16'd0);
                if (a_valid && last_beat) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Extra tile-start flag closes the job's final tile.
                flag_in    = 1'b1;
                state_next = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the last flag shifts out of the register.
                if (flag_shifted == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Nested beat/tile counters so n_tiles*k_len never needs a wide product.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_lat    <= 16'd1;
            n_lat    <= 16'd0;
            beat_cnt <= 16'd0;
            tile_cnt <= 16'd0;
        end else if (launch) begin
            k_lat    <= (k_len == 16'd0) ? 16'd1 : k_len;
            n_lat    <= n_tiles;
            beat_cnt <= 16'd0;
            tile_cnt <= 16'd0;
        end else if (accept) begin
            if (beat_cnt == k_lat - 16'd1) begin
                beat_cnt <= 16'd0;
                tile_cnt <= tile_cnt + 16'd1;
            end else begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    // The first wave of a job only opens tile 0; every later wave reaching
    // PE(1,1) means the previous tile is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_sr    <= '0;
            first_wave <= 1'b0;
            tile_done  <= 1'b0;
            tile_idx   <= 16'd0;
        end else begin
            flag_sr   <= flag_shifted | FLAG_DEPTH'(flag_in);
            tile_done <= flag_sr[FLAG_DEPTH-1] && !first_wave;
            if (launch && (n_tiles != 16'd0)) begin
                first_wave <= 1'b1;
            end else if (flag_sr[FLAG_DEPTH-1]) begin
                first_wave <= 1'b0;
            end
            if (launch) begin
                tile_idx <= 16'd0;
            end else if (tile_done) begin
                tile_idx <= tile_idx + 16'd1;
            end
        end
    end

`ifdef KSEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (launch) begin
            stall_cycles <= 32'd0;
        end else if ((state == STREAM) && !a_valid) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    for (genvar i = 1; i <= SIZE; i++) begin : g_lane
        kseq_skew_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (skew_depth(SIZE, i))
        ) u_left (
            .clk     (clk),
            .rst     (rst),
            .data    (beat_a[i*DATA_WIDTH-1 -: DATA_WIDTH]),
            .delayed (in_left[i*DATA_WIDTH-1 -: DATA_WIDTH])
        );
        kseq_skew_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (skew_depth(SIZE, i))
        ) u_up (
            .clk     (clk),
            .rst     (rst),
            .data    (beat_b[i*DATA_WIDTH-1 -: DATA_WIDTH]),
            .delayed (in_up[i*DATA_WIDTH-1 -: DATA_WIDTH])
        );
    end

    // PE(i,j) sits (SIZE-i)+(SIZE-j) stages down the flag register.
    for (genvar i = 1; i <= SIZE; i++) begin : g_row
        for (genvar j = 1; j <= SIZE; j++) begin : g_col
            assign finish[(i-1)*SIZE+j-1] = flag_sr[2*SIZE-i-j];
        end
    end

endmodule

// File: tb/tb_kseq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kseq_ctrl
// Directed self-checking bench for kseq_ctrl at SIZE=2, DATA_WIDTH=16.
// Define KSEQ_STALL_CNT_EN to also exercise the stall counter.
// ---------------------------------------------------------------------------
module tb_kseq_ctrl;

    localparam int DW = 16;
    localparam int SZ = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      k_len, n_tiles;
    logic             a_valid, a_ready;
    logic [SZ*DW-1:0] a_data, b_data, in_left, in_up;
    logic [SZ*SZ-1:0] finish;
    logic             busy, tile_done;
    logic [15:0]      tile_idx;
`ifdef KSEQ_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    int               done_cnt, first_done, last_done, busy_fall;
    logic [SZ*SZ-1:0] fin_log  [64];
    logic [SZ*DW-1:0] left_log [64];
    logic [SZ*DW-1:0] up_log   [64];
    int               first_done_nostall;

    kseq_ctrl #(
        .DATA_WIDTH (DW),
        .SIZE       (SZ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .n_tiles      (n_tiles),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .b_data       (b_data),
        .in_left      (in_left),
        .in_up        (in_up),
        .finish       (finish),
        .busy         (busy),
        .tile_done    (tile_done),
        .tile_idx     (tile_idx)
`ifdef KSEQ_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic launch(input logic [15:0] k, input logic [15:0] n, input logic v);
        start   = 1'b1;
        k_len   = k;
        n_tiles = n;
        a_valid = v;
        step();
        start   = 1'b0;
    endtask

    // Drives ncyc cycles with a_valid from valid_pat and a cycle-stamped
    // data pattern, logging edge outputs and tile_done activity.
    task automatic applyStimulus(input int ncyc, input logic [63:0] valid_pat);
        done_cnt   = 0;
        first_done = -1;
        last_done  = -1;
        busy_fall  = -1;
        for (int t = 0; t < ncyc; t++) begin
            fin_log[t]  = finish;
            left_log[t] = in_left;
            up_log[t]   = in_up;
            if (tile_done) begin
                checkOutput("tile_idx_at_done", 64'(tile_idx), 64'(done_cnt));
                if (first_done < 0) first_done = t;
                last_done = t;
                done_cnt++;
            end
            if (!busy && busy_fall < 0) busy_fall = t;
            a_valid = valid_pat[t];
            a_data  = {16'(16'hA000 + t), 16'(16'hB000 + t)};
            b_data  = {16'(16'hC000 + t), 16'(16'hD000 + t)};
            step();
        end
        a_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        k_len   = '0;
        n_tiles = '0;
        a_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        step();
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy",     64'(busy),      64'd0);
        checkOutput("rst_a_ready",  64'(a_ready),   64'd0);
        checkOutput("rst_finish",   64'(finish),    64'd0);
        checkOutput("rst_tile_done",64'(tile_done), 64'd0);
        checkOutput("rst_tile_idx", 64'(tile_idx),  64'd0);
        checkOutput("rst_in_left",  64'(in_left),   64'd0);

        $display("[TB] single tile, k_len=2");
        launch(16'd2, 16'd1, 1'b1);
        checkOutput("t1_a_ready", 64'(a_ready), 64'd1);
        applyStimulus(10, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t1_fin_t0", 64'(fin_log[0]), 64'b0000);
        checkOutput("t1_fin_t1", 64'(fin_log[1]), 64'b1000);
        checkOutput("t1_fin_t2", 64'(fin_log[2]), 64'b0110);
        checkOutput("t1_fin_t3", 64'(fin_log[3]), 64'b1001);
        checkOutput("t1_fin_t4", 64'(fin_log[4]), 64'b0110);
        checkOutput("t1_fin_t5", 64'(fin_log[5]), 64'b0001);
        checkOutput("t1_fin_t6", 64'(fin_log[6]), 64'b0000);
        checkOutput("t1_left_t1", 64'(left_log[1]), 64'hA000_0000);
        checkOutput("t1_left_t2", 64'(left_log[2]), 64'hA001_B000);
        checkOutput("t1_left_t3", 64'(left_log[3]), 64'h0000_B001);
        checkOutput("t1_left_t4", 64'(left_log[4]), 64'h0000_0000);
        checkOutput("t1_up_t2",   64'(up_log[2]),   64'hC001_D000);
        checkOutput("t1_up_t3",   64'(up_log[3]),   64'h0000_D001);
        checkOutput("t1_done_cnt",  64'(done_cnt),   64'd1);
        checkOutput("t1_done_at",   64'(first_done), 64'd6);
        checkOutput("t1_busy_fall", 64'(busy_fall),  64'd6);
        first_done_nostall = first_done;

        $display("[TB] single tile with 3-cycle stall");
        launch(16'd2, 16'd1, 1'b1);
        applyStimulus(12, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("t2_left_t1", 64'(left_log[1][31:16]), 64'hA000);
        checkOutput("t2_bubble",  64'(left_log[3][31:16]), 64'h0000);
        checkOutput("t2_left_t5", 64'(left_log[5][31:16]), 64'hA004);
        checkOutput("t2_fin3_t1", 64'(fin_log[1][3]), 64'd1);
        checkOutput("t2_fin3_t3", 64'(fin_log[3][3]), 64'd0);
        checkOutput("t2_fin3_t6", 64'(fin_log[6][3]), 64'd1);
        checkOutput("t2_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("t2_done_delay", 64'(first_done - first_done_nostall), 64'd3);
`ifdef KSEQ_STALL_CNT_EN
        checkOutput("t2_stall_cycles", 64'(stall_cycles), 64'd3);
`endif

        $display("[TB] three tiles, k_len=4");
        launch(16'd4, 16'd3, 1'b1);
        applyStimulus(20, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t3_done_cnt",   64'(done_cnt),   64'd3);
        checkOutput("t3_first_done", 64'(first_done), 64'd8);
        checkOutput("t3_last_done",  64'(last_done),  64'd16);
        checkOutput("t3_busy_fall",  64'(busy_fall),  64'd16);
        checkOutput("t3_tile_idx_end", 64'(tile_idx), 64'd3);

        $display("[TB] zero-tile start");
        launch(16'd4, 16'd0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            checkOutput("t4_busy",   64'(busy),   64'd0);
            checkOutput("t4_finish", 64'(finish), 64'd0);
            step();
        end

        $display("[TB] reset mid-stream, then restart");
        launch(16'd2, 16'd2, 1'b1);
        a_valid = 1'b1;
        a_data  = 32'h1234_5678;
        b_data  = 32'h9ABC_DEF0;
        step();
        step();
        checkOutput("t5_left_pre", 64'(in_left), 64'h1234_5678);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t5_busy",      64'(busy),      64'd0);
        checkOutput("t5_a_ready",   64'(a_ready),   64'd0);
        checkOutput("t5_finish",    64'(finish),    64'd0);
        checkOutput("t5_tile_done", 64'(tile_done), 64'd0);
        checkOutput("t5_tile_idx",  64'(tile_idx),  64'd0);
        checkOutput("t5_in_left",   64'(in_left),   64'd0);
        checkOutput("t5_in_up",     64'(in_up),     64'd0);
        launch(16'd0, 16'd1, 1'b0);
        applyStimulus(14, 64'hFFFF_FFFF_FFFF_FFE0);
        checkOutput("t5_done_cnt",  64'(done_cnt),   64'd1);
        checkOutput("t5_done_at",   64'(first_done), 64'd10);
        checkOutput("t5_busy_fall", 64'(busy_fall),  64'd10);
        checkOutput("t5_left_t6",   64'(left_log[6][31:16]), 64'hA005);
`ifdef KSEQ_STALL_CNT_EN
        checkOutput("t5_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
